pipe_stage_buf: RTL and testbench
=================================

// Module: pipe_stage_buf
// PURPOSE
//  Parametrised elastic pipeline stage; next generation of the fixed ID/EX latch.
//  Carries a WIDTH-bit payload between any two stages (IF/ID, ID/EX, EX/MEM) with valid/ready
//  handshake, DEPTH-entry buffering, flush (jump/mispredict) and global rdy freeze.
//  Replaces per-stage hand-written latches; emits zero bubbles like the old stall_ctrler path.
// PARAMETERS
//  WIDTH  64  payload bits (pc|inst|vs1|vs2|rd|imm|flags packed by caller)
//  DEPTH  1   entries; 1 = classic pipeline register, 2..8 = FIFO buffer
//  CNT_W  16  width of perf counters (PIPE_STAGE_PERF_EN only)
// PORTS
//  clk        in   1                   clock, posedge
//  rst        in   1                   synchronous reset, active-low
//  rdy        in   1                   global enable; low = freeze all state
//  flush      in   1                   discard all entries (jump_enable)
//  in_valid   in   1                   upstream has payload
//  in_ready   out  1                   stage accepts payload this cycle
//  in_data    in   WIDTH               upstream payload
//  out_valid  out  1                   head entry valid
//  out_ready  in   1                   downstream consumes head (stall = low)
//  out_data   out  WIDTH               head payload; all-zero when empty
//  count      out  $clog2(DEPTH+1)     current occupancy
//  stall_cnt  out  CNT_W               cycles out_valid&&!out_ready (PERF only)
//  flush_cnt  out  CNT_W               flush events (PERF only)
// BEHAVIOUR
//  - Reset (rst==0 at posedge): count=0, out_valid=0, out_data=0, perf counters=0.
//    Reset beats rdy and flush. Reset mid-transfer drops all entries, no partial state.
//  - push = in_valid&&in_ready; pop = out_valid&&out_ready; both sampled at posedge.
//  - rdy==0: in_ready=0, out_valid=0 (combinational gating); storage, pointers, count,
//    counters held. Contents reappear unchanged when rdy returns.
//  - flush==1 (rdy==1): next edge count=0, pointers=0; simultaneous push discarded,
//    pop ignored. in_ready still reports normal value during flush cycle.
//  - DEPTH==1: in_ready = !full || out_ready (same-cycle pass-through; comb path
//    out_ready->in_ready). Push+pop when full replaces entry, count stays 1.
//    Latency 1 cycle, throughput 1/cycle.
//  - DEPTH>=2: in_ready = (count!=DEPTH), registered-only, no comb path from out_ready.
//    Circular buffer, rd/wr pointers wrap DEPTH-1 -> 0 (non-power-of-2 DEPTH legal).
//    Push+pop when full not allowed (in_ready=0); push+pop when empty: entry written,
//    out_valid next cycle (no bypass). Latency 1 cycle; full throughput at count 1..DEPTH-1.
//  - count: +1 push only, -1 pop only, unchanged both/neither; never exceeds DEPTH.
//  - out_data = mem[rd_ptr] when count!=0 else WIDTH'b0 (bubble = all-zero, decodes as NOP).
//  - Caller must hold in_data stable while in_valid&&!in_ready; buffer does not check.
//  - Parameter check: DEPTH<1 or DEPTH>8 -> $error at elaboration.
// CONFIGURATION
//  PIPE_STAGE_PERF_EN defined: stall_cnt +1 each rdy cycle with out_valid&&!out_ready;
//    flush_cnt +1 each rdy cycle with flush; both saturate at 2^CNT_W-1, cleared by rst.
//  Undefined: stall_cnt/flush_cnt ports tied to 0, no counter flops synthesised.
// STRUCTURE
//  - Shared header config.v: `Enable/`Disable, `ZeroWord; add PIPE_MAX_DEPTH (8).
//  - Sub-module pipe_stage_mem: DEPTH x WIDTH register array, 1 write port, 1 async read
//    port; no reset on data (out_data zeroing done in parent by count==0 mux).
//  - Parent holds pointers, count, handshake logic, perf counters.
// TESTING
//  - DEPTH=1: push 0xA5 cycles 1..4 with out_ready=1 -> out_data 0xA5.. 1 cycle later, no gaps.
//  - DEPTH=2: out_ready=0, push 3 words -> in_ready=0 after 2nd, count=2, 3rd not taken;
//    release out_ready -> words out in order.
//  - DEPTH=3 wrap: 10 push/pop cycles random out_ready -> order preserved, ptrs wrap 2->0.
//  - flush with count=2 and concurrent push -> next cycle count=0, out_valid=0, out_data=0.
//  - rdy=0 for 5 cycles with count=1 -> in_ready=out_valid=0, contents unchanged after.
//  - PERF: hold out_ready=0 for 20 cycles, flush twice -> stall_cnt=20, flush_cnt=2;
//    CNT_W=4, 30 stalls -> stall_cnt=15. rst=0 mid-run -> all outputs 0 next edge.

Source files
------------

// File: rtl/pipe_stage_buf_pkg.sv
// Shared constants and types for the elastic pipeline stage (pipe_stage_buf).
package pipe_stage_buf_pkg;

  localparam int PIPE_MAX_DEPTH = 8;

  typedef struct packed {
    logic push;
    logic pop;
  } xfer_t;

  function automatic int ptr_width(input int depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

endpackage

// File: rtl/pipe_stage_mem.sv
// DEPTH x WIDTH payload storage for pipe_stage_buf: one write port, one async read port.
module pipe_stage_mem #(
  parameter int WIDTH = 64,
  parameter int DEPTH = 1,
  parameter int PTR_W = 1
) (
  input  logic             clk,
  input  logic             we,
  input  logic [PTR_W-1:0] waddr,
  input  logic [WIDTH-1:0] wdata,
  input  logic [PTR_W-1:0] raddr,
  output logic [WIDTH-1:0] rdata
);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] mem_d [DEPTH];

  // Payload is never reset; the parent masks stale entries using its occupancy count.
  always_comb begin
    mem_d = mem_q;
    if (we) begin
      mem_d[waddr] = wdata;
    end
  end

  always_ff @(posedge clk) begin
    mem_q <= mem_d;
  end

  assign rdata = mem_q[raddr];

endmodule

// File: rtl/pipe_stage_buf.sv
// Elastic pipeline stage: WIDTH-bit payload, DEPTH-entry buffer, valid/ready, flush and rdy freeze.
// Define PIPE_STAGE_PERF_EN to build the saturating stall/flush performance counters.
module pipe_stage_buf
  import pipe_stage_buf_pkg::*;
#(
  parameter int WIDTH = 64,
  parameter int DEPTH = 1,
  parameter int CNT_W = 16
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         rdy,
  input  logic                         flush,
  input  logic                         in_valid,
  output logic                         in_ready,
  input  logic [WIDTH-1:0]             in_data,
  output logic                         out_valid,
  input  logic                         out_ready,
  output logic [WIDTH-1:0]             out_data,
  output logic [$clog2(DEPTH+1)-1:0]   count,
  output logic [CNT_W-1:0]             stall_cnt,
  output logic [CNT_W-1:0]             flush_cnt
);

  localparam int PTR_W = ptr_width(DEPTH);
  localparam int CW    = $clog2(DEPTH + 1);

  if (DEPTH < 1 || DEPTH > PIPE_MAX_DEPTH) begin : g_depth_chk
    $error("pipe_stage_buf: DEPTH=%0d outside legal range 1..%0d", DEPTH, PIPE_MAX_DEPTH);
  end

  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [CW-1:0]    count_q, count_d;
  logic             full;
  logic             empty;
  logic             mem_we;
  logic [WIDTH-1:0] rd_data;
  xfer_t            xfer;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  assign full  = (count_q == CW'(DEPTH));
  assign empty = (count_q == '0);

  // A single-entry stage may refill in the same cycle it drains; deeper stages stay registered.
  if (DEPTH == 1) begin : g_pass
    assign in_ready = rdy && (!full || out_ready);
  end else begin : g_fifo
    assign in_ready = rdy && !full;
  end

  assign out_valid = rdy && !empty;

  always_comb begin
    xfer.push = in_valid && in_ready;
    xfer.pop  = out_valid && out_ready;
  end

  always_comb begin
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    count_d  = count_q;
    mem_we   = 1'b0;
    if (rdy) begin
      if (flush) begin
        rd_ptr_d = '0;
        wr_ptr_d = '0;
        count_d  = '0;
      end else begin
        if (xfer.push) begin
          mem_we   = 1'b1;
          wr_ptr_d = ptr_inc(wr_ptr_q);
        end
        if (xfer.pop) begin
          rd_ptr_d = ptr_inc(rd_ptr_q);
        end
        if (xfer.push && !xfer.pop) begin
          count_d = count_q + CW'(1);
        end else if (xfer.pop && !xfer.push) begin
          count_d = count_q - CW'(1);
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      count_q  <= count_d;
    end
  end

  pipe_stage_mem #(
    .WIDTH (WIDTH),
    .DEPTH (DEPTH),
    .PTR_W (PTR_W)
  ) u_mem (
    .clk   (clk),
    .we    (mem_we),
    .waddr (wr_ptr_q),
    .wdata (in_data),
    .raddr (rd_ptr_q),
    .rdata (rd_data)
  );

  // An empty stage presents an all-zero bubble so downstream decode sees a NOP.
  assign out_data = empty ? '0 : rd_data;
  assign count    = count_q;

`ifdef PIPE_STAGE_PERF_EN
  logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
  logic [CNT_W-1:0] flush_cnt_q, flush_cnt_d;

  always_comb begin
    stall_cnt_d = stall_cnt_q;
    flush_cnt_d = flush_cnt_q;
    if (rdy) begin
      if (out_valid && !out_ready && (stall_cnt_q != '1)) begin
        stall_cnt_d = stall_cnt_q + 1'b1;
      end
      if (flush && (flush_cnt_q != '1)) begin
        flush_cnt_d = flush_cnt_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      stall_cnt_q <= stall_cnt_d;
      flush_cnt_q <= flush_cnt_d;
    end
  end

  assign stall_cnt = stall_cnt_q;
  assign flush_cnt = flush_cnt_q;
`else
  assign stall_cnt = '0;
  assign flush_cnt = '0;
`endif

endmodule

// File: tb/tb_pipe_stage_buf.sv
// Bench for pipe_stage_buf: DEPTH 1/2/3 instances share directed stimulus and are checked against a queue model.
module tb_pipe_stage_buf;

  localparam int W = 16;
`ifdef PIPE_STAGE_PERF_EN
  localparam bit PERF_ON = 1'b1;
`else
  localparam bit PERF_ON = 1'b0;
`endif

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic         rst, rdy, flush, in_valid, out_ready;
  logic [W-1:0] in_data;

  logic         d1_ir, d1_ov;
  logic [W-1:0] d1_od;
  logic [0:0]   d1_cn;
  logic [15:0]  d1_sc, d1_fc;

  logic         d2_ir, d2_ov;
  logic [W-1:0] d2_od;
  logic [1:0]   d2_cn;
  logic [3:0]   d2_sc, d2_fc;

  logic         d3_ir, d3_ov;
  logic [W-1:0] d3_od;
  logic [1:0]   d3_cn;
  logic [15:0]  d3_sc, d3_fc;

  int checks = 0;
  int errors = 0;
  bit model_ready = 1'b0;

  logic [W-1:0] mq [3][8];
  int mcnt [3];
  int msc [3];
  int mfc [3];

  pipe_stage_buf #(.WIDTH(W), .DEPTH(1), .CNT_W(16)) u_d1 (
    .clk(clk), .rst(rst), .rdy(rdy), .flush(flush),
    .in_valid(in_valid), .in_ready(d1_ir), .in_data(in_data),
    .out_valid(d1_ov), .out_ready(out_ready), .out_data(d1_od),
    .count(d1_cn), .stall_cnt(d1_sc), .flush_cnt(d1_fc)
  );

  pipe_stage_buf #(.WIDTH(W), .DEPTH(2), .CNT_W(4)) u_d2 (
    .clk(clk), .rst(rst), .rdy(rdy), .flush(flush),
    .in_valid(in_valid), .in_ready(d2_ir), .in_data(in_data),
    .out_valid(d2_ov), .out_ready(out_ready), .out_data(d2_od),
    .count(d2_cn), .stall_cnt(d2_sc), .flush_cnt(d2_fc)
  );

  pipe_stage_buf #(.WIDTH(W), .DEPTH(3), .CNT_W(16)) u_d3 (
    .clk(clk), .rst(rst), .rdy(rdy), .flush(flush),
    .in_valid(in_valid), .in_ready(d3_ir), .in_data(in_data),
    .out_valid(d3_ov), .out_ready(out_ready), .out_data(d3_od),
    .count(d3_cn), .stall_cnt(d3_sc), .flush_cnt(d3_fc)
  );

  function automatic int dep(input int i);
    return i + 1;
  endfunction

  function automatic int sat(input int i);
    return (i == 1) ? 15 : 65535;
  endfunction

  function automatic string fname(input int f);
    case (f)
      0:       return "in_ready";
      1:       return "out_valid";
      2:       return "out_data";
      3:       return "count";
      4:       return "stall_cnt";
      default: return "flush_cnt";
    endcase
  endfunction

  // Model view: stage accepts when rdy and there is room (depth 1 also when the head leaves).
  function automatic int exp_val(input int i, input int f);
    case (f)
      0: return (rdy && ((dep(i) == 1) ? (mcnt[i] == 0 || out_ready) : (mcnt[i] != dep(i)))) ? 1 : 0;
      1: return (rdy && mcnt[i] > 0) ? 1 : 0;
      2: return (mcnt[i] > 0) ? int'(mq[i][0]) : 0;
      3: return mcnt[i];
      4: return PERF_ON ? msc[i] : 0;
      default: return PERF_ON ? mfc[i] : 0;
    endcase
  endfunction

  function automatic int act_val(input int i, input int f);
    logic [31:0] v;
    v = '0;
    case (i)
      0: case (f)
           0: v = 32'(d1_ir);  1: v = 32'(d1_ov);  2: v = 32'(d1_od);
           3: v = 32'(d1_cn);  4: v = 32'(d1_sc);  default: v = 32'(d1_fc);
         endcase
      1: case (f)
           0: v = 32'(d2_ir);  1: v = 32'(d2_ov);  2: v = 32'(d2_od);
           3: v = 32'(d2_cn);  4: v = 32'(d2_sc);  default: v = 32'(d2_fc);
         endcase
      default: case (f)
           0: v = 32'(d3_ir);  1: v = 32'(d3_ov);  2: v = 32'(d3_od);
           3: v = 32'(d3_cn);  4: v = 32'(d3_sc);  default: v = 32'(d3_fc);
         endcase
    endcase
    return int'(v);
  endfunction

  task automatic check_output(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Advance the model across one clock edge using the inputs presented before it.
  task automatic model_step();
    for (int i = 0; i < 3; i++) begin
      int ov_e, ir_e;
      ov_e = exp_val(i, 1);
      ir_e = exp_val(i, 0);
      if (!rst) begin
        mcnt[i] = 0;
        msc[i]  = 0;
        mfc[i]  = 0;
      end else if (rdy) begin
        if (ov_e == 1 && !out_ready && msc[i] < sat(i)) msc[i]++;
        if (flush) begin
          mcnt[i] = 0;
          if (mfc[i] < sat(i)) mfc[i]++;
        end else begin
          if (ov_e == 1 && out_ready) begin
            for (int k = 0; k < 7; k++) mq[i][k] = mq[i][k+1];
            mcnt[i]--;
          end
          if (in_valid && ir_e == 1) begin
            mq[i][mcnt[i]] = in_data;
            mcnt[i]++;
          end
        end
      end
    end
    if (!rst) model_ready = 1'b1;
  endtask

  task automatic apply_stimulus(input logic r, input logic en, input logic fl,
                                input logic iv, input logic [W-1:0] d, input logic ordy);
    rst       = r;
    rdy       = en;
    flush     = fl;
    in_valid  = iv;
    in_data   = d;
    out_ready = ordy;
    @(negedge clk);
    #2;
    model_step();
    @(posedge clk);
    #1;
  endtask

  always @(negedge clk) begin
    if (model_ready) begin
      for (int i = 0; i < 3; i++) begin
        for (int f = 0; f < 6; f++) begin
          check_output($sformatf("%s_d%0d", fname(f), dep(i)), act_val(i, f), exp_val(i, f));
        end
      end
    end
  end

  initial begin
    logic [9:0] wrap_pat;
    wrap_pat = 10'b1011001101;
    for (int i = 0; i < 3; i++) begin
      mcnt[i] = 0;
      msc[i]  = 0;
      mfc[i]  = 0;
    end
    rst = 1'b0; rdy = 1'b1; flush = 1'b0; in_valid = 1'b0; in_data = '0; out_ready = 1'b0;
    @(posedge clk);
    #1;

    apply_stimulus(1'b0, 1'b1, 1'b0, 1'b0, 16'h0, 1'b0);
    apply_stimulus(1'b0, 1'b1, 1'b0, 1'b0, 16'h0, 1'b0);
    check_output("lit_reset_count_d1", int'(d1_cn), 0);
    check_output("lit_reset_data_d2", int'(d2_od), 0);
    check_output("lit_reset_valid_d3", int'(d3_ov), 0);

    $display("[TB] depth-1 back-to-back pass-through");
    for (int i = 0; i < 4; i++) begin
      apply_stimulus(1'b1, 1'b1, 1'b0, 1'b1, 16'(16'hA5 + i), 1'b1);
      check_output("lit_pass_data_d1", int'(d1_od), 16'hA5 + i);
      check_output("lit_pass_valid_d1", int'(d1_ov), 1);
    end
    for (int i = 0; i < 3; i++) apply_stimulus(1'b1, 1'b1, 1'b0, 1'b0, 16'h0, 1'b1);
    check_output("lit_drain_count_d3", int'(d3_cn), 0);
    check_output("lit_drain_data_d1", int'(d1_od), 0);

    $display("[TB] depth-2 backpressure");
    apply_stimulus(1'b1, 1'b1, 1'b0, 1'b1, 16'h0011, 1'b0);
    apply_stimulus(1'b1, 1'b1, 1'b0, 1'b1, 16'h0022, 1'b0);
    apply_stimulus(1'b1, 1'b1, 1'b0, 1'b1, 16'h0033, 1'b0);
    check_output("lit_bp_count_d2", int'(d2_cn), 2);
    check_output("lit_bp_ready_d2", int'(d2_ir), 0);
    check_output("lit_bp_head_d2", int'(d2_od), 16'h0011);
    check_output("lit_bp_count_d3", int'(d3_cn), 3);
    apply_stimulus(1'b1, 1'b1, 1'b0, 1'b0, 16'h0, 1'b1);
    check_output("lit_release_head_d2", int'(d2_od), 16'h0022);
    apply_stimulus(1'b1, 1'b1, 1'b0, 1'b0, 16'h0, 1'b1);
    check_output("lit_release_head_d3", int'(d3_od), 16'h0033);
    apply_stimulus(1'b1, 1'b1, 1'b0, 1'b0, 16'h0, 1'b1);

    $display("[TB] depth-3 pointer wrap");
    for (int i = 0; i < 10; i++) begin
      apply_stimulus(1'b1, 1'b1, 1'b0, 1'b1, 16'(16'h0040 + i), wrap_pat[i]);
    end
    for (int i = 0; i < 5; i++) apply_stimulus(1'b1, 1'b1, 1'b0, 1'b0, 16'h0, 1'b1);
    check_output("lit_wrap_count_d3", int'(d3_cn), 0);

    $display("[TB] flush with concurrent push");
    apply_stimulus(1'b1, 1'b1, 1'b0, 1'b1, 16'h0055, 1'b0);
    apply_stimulus(1'b1, 1'b1, 1'b0, 1'b1, 16'h0066, 1'b0);
    check_output("lit_preflush_count_d2", int'(d2_cn), 2);
    apply_stimulus(1'b1, 1'b1, 1'b1, 1'b1, 16'h0077, 1'b0);
    check_output("lit_flush_count_d2", int'(d2_cn), 0);
    check_output("lit_flush_valid_d2", int'(d2_ov), 0);
    check_output("lit_flush_data_d2", int'(d2_od), 0);
    check_output("lit_flush_data_d3", int'(d3_od), 0);

    $display("[TB] rdy freeze");
    apply_stimulus(1'b1, 1'b1, 1'b0, 1'b1, 16'h0099, 1'b0);
    for (int i = 0; i < 5; i++) begin
      apply_stimulus(1'b1, 1'b0, 1'b0, 1'b1, 16'h00EE, 1'b1);
      check_output("lit_freeze_ready_d1", int'(d1_ir), 0);
      check_output("lit_freeze_valid_d1", int'(d1_ov), 0);
    end
    apply_stimulus(1'b1, 1'b1, 1'b0, 1'b0, 16'h0, 1'b0);
    check_output("lit_thaw_count_d1", int'(d1_cn), 1);
    check_output("lit_thaw_data_d1", int'(d1_od), 16'h0099);
    check_output("lit_thaw_data_d2", int'(d2_od), 16'h0099);

    $display("[TB] performance counters");
    apply_stimulus(1'b0, 1'b1, 1'b0, 1'b0, 16'h0, 1'b0);
    apply_stimulus(1'b1, 1'b1, 1'b0, 1'b1, 16'h00C3, 1'b0);
    for (int i = 0; i < 20; i++) apply_stimulus(1'b1, 1'b1, 1'b0, 1'b0, 16'h0, 1'b0);
    apply_stimulus(1'b1, 1'b1, 1'b1, 1'b0, 16'h0, 1'b1);
    apply_stimulus(1'b1, 1'b1, 1'b1, 1'b0, 16'h0, 1'b1);
`ifdef PIPE_STAGE_PERF_EN
    check_output("lit_stall_d1", int'(d1_sc), 20);
    check_output("lit_flushcnt_d1", int'(d1_fc), 2);
    check_output("lit_stall_sat_d2", int'(d2_sc), 15);
    check_output("lit_stall_d3", int'(d3_sc), 20);
`else
    check_output("lit_stall_off_d1", int'(d1_sc), 0);
    check_output("lit_flushcnt_off_d1", int'(d1_fc), 0);
`endif

    $display("[TB] reset mid-run beats rdy and flush");
    apply_stimulus(1'b1, 1'b1, 1'b0, 1'b1, 16'h00D1, 1'b0);
    apply_stimulus(1'b0, 1'b0, 1'b1, 1'b1, 16'h00D2, 1'b0);
    check_output("lit_midrst_count_d1", int'(d1_cn), 0);
    check_output("lit_midrst_data_d1", int'(d1_od), 0);
    check_output("lit_midrst_stall_d2", int'(d2_sc), 0);
    check_output("lit_midrst_flushcnt_d1", int'(d1_fc), 0);
    apply_stimulus(1'b1, 1'b1, 1'b0, 1'b0, 16'h0, 1'b1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
